fnn_input_feeder: RTL and testbench
===================================

Name: fnn_input_feeder

Overview:
- Upstream stage of control_FNN. Collects one image of NO_OF_INPUTS raw pixels from a valid/ready pixel source into an on-chip frame buffer.
- Once weights are loaded (FNN_ready), it streams scaled pixels to the FNN under FNN_ready_to_accept flow control.
- It captures the classified digit on finish_FNN, then re-arms the FNN with a restart pulse.
- Replaces the bench-side sequencing with synthesizable RTL.

Parameters:
- NO_OF_INPUTS, 784, pixels per image and frame buffer depth
- PIXEL_WIDTH, 8, raw pixel width from the source
- INDATA_WIDTH, 16, FNN input word width
- PIXEL_SHIFT, 7, left shift applied when widening a pixel. Elaboration check: PIXEL_WIDTH+PIXEL_SHIFT <= INDATA_WIDTH.
- NN_OUT, 10, number of valid classes

Ports:
- clk  in  1  system clock, rising edge
- restart  in  1  synchronous active-high reset
- pix_valid  in  1  source has a pixel
- pix_data  in  PIXEL_WIDTH  raw pixel, unsigned
- pix_ready  out  1  feeder accepts a pixel this cycle
- fnn_ready  in  1  from FNN_ready (weights loaded)
- fnn_accept  in  1  from FNN_ready_to_accept
- start_fnn  out  1  to start_FNN
- ready_in  out  1  to ready_in
- input_image  out  INDATA_WIDTH  to input_image
- finish_fnn  in  1  from finish_FNN
- max_in  in  4  from max
- fnn_restart  out  1  to FNN restart
- result_valid  out  1  one-cycle pulse, result_class valid
- result_class  out  4  captured class
- result_err  out  1  captured class >= NN_OUT
- frames_done  out  16  completed-frame counter

Behaviour:
- One clock: clk. Reset is synchronous, active-high, on restart. The clock and reset names are fixed.
- Reset values: every output 0 (pix_ready included), write and read pointers 0, state FILL. Reset mid-operation aborts immediately: the buffer is discarded and no fnn_restart pulse is issued.
- States: FILL, ARM, STREAM, WAIT_RES, REARM.
- FILL
  - pix_ready=1.
  - A transfer occurs on a rising edge with pix_valid&&pix_ready. mem[wr_ptr] <= pix_data, wr_ptr++.
  - pix_valid with pix_ready=0 is not a transfer; the source holds its data.
  - The transfer at wr_ptr==NO_OF_INPUTS-1 sets wr_ptr=0 and moves to ARM. pix_ready drops in the next cycle.
- ARM
  - Wait for fnn_ready=1, then set start_fnn=1 and ready_in=1 and move to STREAM.
  - If fnn_ready is already 1, ARM lasts exactly one cycle.
- STREAM
  - start_fnn and ready_in stay 1.
  - On each rising edge with fnn_accept=1 and rd_ptr<NO_OF_INPUTS: input_image <= zero-extended (mem[rd_ptr] << PIXEL_SHIFT), rd_ptr++.
  - input_image holds its value when fnn_accept=0.
  - Once rd_ptr reaches NO_OF_INPUTS, further fnn_accept is ignored and the state moves to WAIT_RES.
- WAIT_RES
  - On finish_fnn=1: result_class <= max_in, result_err <= (max_in>=NN_OUT), result_valid=1 for one cycle, frames_done++ (wraps 65535->0). Move to REARM.
  - result_class and result_err hold until the next capture.
- REARM
  - One cycle: fnn_restart=1; start_fnn, ready_in and rd_ptr cleared. Next state FILL.
- finish_fnn outside WAIT_RES is ignored.
- Latency: the first input_image update is the first fnn_accept edge after start_fnn rises. result_valid is the edge after finish_fnn is sampled.

Optional Feature:
- Macro: FNN_FEEDER_DOUBLE_BUFFER_EN.
- Defined
  - Two banks of NO_OF_INPUTS.
  - The fill side writes the bank not being streamed. pix_ready=1 in any state while the fill bank is not full.
  - In REARM the banks swap. If the new stream bank is full, go to ARM instead of FILL.
  - Reset empties both banks.
- Undefined
  - Single bank. pix_ready=1 only in FILL.

Test Plan:
1. Reset then fill: pixels 0..783 (value = index mod 256), fnn_ready=1, fnn_accept=1 continuous.
   -> start_fnn=1 one cycle after the last pixel. input_image sequence = (i mod 256)<<7; pixel 255 -> 0x7F80. Exactly 784 updates.
2. fnn_accept toggled 1/0 every cycle during STREAM.
   -> input_image changes only on accept edges; 784 distinct updates; no skipped or repeated pixel.
3. finish_fnn with max_in=4'd2.
   -> result_valid one pulse, result_class=2, result_err=0, frames_done=1. fnn_restart one cycle later, then pix_ready=1 in FILL.
4. max_in=4'd12 on finish.
   -> result_class=12, result_err=1.
5. restart asserted at pixel 400 of STREAM.
   -> next cycle all outputs 0, fnn_restart=0, state FILL with wr_ptr=0. A fresh 784-pixel frame is required before start_fnn.
6. With FNN_FEEDER_DOUBLE_BUFFER_EN: a second frame is fed during STREAM.
   -> pix_ready stays 1 while the FNN streams; after REARM, start_fnn rises without a FILL phase.

Source files
------------

// File: rtl/fnn_input_feeder.sv
// fnn_input_feeder: frame buffer and sequencer in front of control_FNN.
// Define FNN_FEEDER_DOUBLE_BUFFER_EN for a ping-pong frame buffer.
module fnn_input_feeder #(
  parameter int NO_OF_INPUTS = 784,
  parameter int PIXEL_WIDTH  = 8,
  parameter int INDATA_WIDTH = 16,
  parameter int PIXEL_SHIFT  = 7,
  parameter int NN_OUT       = 10
) (
  input  logic                    clk,
  input  logic                    restart,
  input  logic                    pix_valid,
  input  logic [PIXEL_WIDTH-1:0]  pix_data,
  output logic                    pix_ready,
  input  logic                    fnn_ready,
  input  logic                    fnn_accept,
  output logic                    start_fnn,
  output logic                    ready_in,
  output logic [INDATA_WIDTH-1:0] input_image,
  input  logic                    finish_fnn,
  input  logic [3:0]              max_in,
  output logic                    fnn_restart,
  output logic                    result_valid,
  output logic [3:0]              result_class,
  output logic                    result_err,
  output logic [15:0]             frames_done
);
  localparam int PW = $clog2(NO_OF_INPUTS + 1);
  localparam logic [PW-1:0] LAST = PW'(NO_OF_INPUTS - 1);
  localparam logic [PW-1:0] NUM  = PW'(NO_OF_INPUTS);
  localparam logic [4:0] NN_OUT_W = 5'(NN_OUT);

  localparam logic [2:0] S_FILL   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_REARM  = 3'd4;

  if (PIXEL_WIDTH + PIXEL_SHIFT > INDATA_WIDTH) begin : g_width_chk
    $error("PIXEL_WIDTH+PIXEL_SHIFT exceeds INDATA_WIDTH");
  end

  logic [2:0]              state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic                    pix_ready_q, pix_ready_d;
  logic                    start_fnn_q, start_fnn_d;
  logic                    ready_in_q, ready_in_d;
  logic [INDATA_WIDTH-1:0] input_image_q, input_image_d;
  logic                    fnn_restart_q, fnn_restart_d;
  logic                    result_valid_q, result_valid_d;
  logic [3:0]              result_class_q, result_class_d;
  logic                    result_err_q, result_err_d;
  logic [15:0]             frames_done_q, frames_done_d;
  logic                    wr_en;
  logic                    fill_last;
  logic [PIXEL_WIDTH-1:0]  rd_pix;

`ifdef FNN_FEEDER_DOUBLE_BUFFER_EN
  logic [PIXEL_WIDTH-1:0] mem [2][NO_OF_INPUTS];
  logic       sb_q, sb_d;
  logic [1:0] full_q, full_d;
  logic       wb, nb;

  // While idle in FILL the fill side loads the bank that streams next.
  assign wb     = (state_q == S_FILL) ? sb_q : ~sb_q;
  assign rd_pix = mem[sb_q][rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en && !restart) mem[wb][wr_ptr_q] <= pix_data;
  end
`else
  logic [PIXEL_WIDTH-1:0] mem [NO_OF_INPUTS];

  assign rd_pix = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en && !restart) mem[wr_ptr_q] <= pix_data;
  end
`endif

  assign wr_en     = pix_valid && pix_ready_q;
  assign fill_last = wr_en && (wr_ptr_q == LAST);

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    start_fnn_d    = start_fnn_q;
    ready_in_d     = ready_in_q;
    input_image_d  = input_image_q;
    fnn_restart_d  = 1'b0;
    result_valid_d = 1'b0;
    result_class_d = result_class_q;
    result_err_d   = result_err_q;
    frames_done_d  = frames_done_q;
`ifdef FNN_FEEDER_DOUBLE_BUFFER_EN
    sb_d   = sb_q;
    full_d = full_q;
    nb     = 1'b0;
    if (fill_last) full_d[wb] = 1'b1;
`endif
    if (wr_en) wr_ptr_d = fill_last ? '0 : wr_ptr_q + PW'(1);

    unique case (1'b1)
      (state_q == S_FILL): begin
        if (fill_last) state_d = S_ARM;
      end
      (state_q == S_ARM): begin
        if (fnn_ready) begin
          start_fnn_d = 1'b1;
          ready_in_d  = 1'b1;
          state_d     = S_STREAM;
        end
      end
      (state_q == S_STREAM): begin
        if (rd_ptr_q >= NUM) begin
          state_d = S_WAIT;
        end else if (fnn_accept) begin
          input_image_d = INDATA_WIDTH'(rd_pix) << PIXEL_SHIFT;
          rd_ptr_d      = rd_ptr_q + PW'(1);
          if (rd_ptr_q == LAST) state_d = S_WAIT;
        end
      end
      (state_q == S_WAIT): begin
        if (finish_fnn) begin
          result_class_d = max_in;
          result_err_d   = ({1'b0, max_in} >= NN_OUT_W);
          result_valid_d = 1'b1;
          frames_done_d  = frames_done_q + 16'd1;
          state_d        = S_REARM;
        end
      end
      (state_q == S_REARM): begin
        fnn_restart_d = 1'b1;
        start_fnn_d   = 1'b0;
        ready_in_d    = 1'b0;
        rd_ptr_d      = '0;
        state_d       = S_FILL;
`ifdef FNN_FEEDER_DOUBLE_BUFFER_EN
        full_d[sb_q] = 1'b0;
        sb_d         = ~sb_q;
        if (full_d[~sb_q]) state_d = S_ARM;
`endif
      end
      default: state_d = S_FILL;
    endcase

`ifdef FNN_FEEDER_DOUBLE_BUFFER_EN
    nb          = (state_d == S_FILL) ? sb_d : ~sb_d;
    pix_ready_d = !full_d[nb];
`else
    pix_ready_d = (state_d == S_FILL);
`endif
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q        <= S_FILL;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      pix_ready_q    <= 1'b0;
      start_fnn_q    <= 1'b0;
      ready_in_q     <= 1'b0;
      input_image_q  <= '0;
      fnn_restart_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      result_err_q   <= 1'b0;
      frames_done_q  <= '0;
`ifdef FNN_FEEDER_DOUBLE_BUFFER_EN
      sb_q           <= 1'b0;
      full_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      pix_ready_q    <= pix_ready_d;
      start_fnn_q    <= start_fnn_d;
      ready_in_q     <= ready_in_d;
      input_image_q  <= input_image_d;
      fnn_restart_q  <= fnn_restart_d;
      result_valid_q <= result_valid_d;
      result_class_q <= result_class_d;
      result_err_q   <= result_err_d;
      frames_done_q  <= frames_done_d;
`ifdef FNN_FEEDER_DOUBLE_BUFFER_EN
      sb_q           <= sb_d;
      full_q         <= full_d;
`endif
    end
  end

  assign pix_ready    = pix_ready_q;
  assign start_fnn    = start_fnn_q;
  assign ready_in     = ready_in_q;
  assign input_image  = input_image_q;
  assign fnn_restart  = fnn_restart_q;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign result_err   = result_err_q;
  assign frames_done  = frames_done_q;
endmodule

// File: tb/tb_fnn_input_feeder.sv
// tb_fnn_input_feeder: directed bench for fnn_input_feeder.
// Build with FNN_FEEDER_DOUBLE_BUFFER_EN to also exercise the ping-pong path.
module tb_fnn_input_feeder;
  localparam int N = 784;

  logic        clk;
  logic        restart;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        fnn_ready;
  logic        fnn_accept;
  logic        start_fnn;
  logic        ready_in;
  logic [15:0] input_image;
  logic        finish_fnn;
  logic [3:0]  max_in;
  logic        fnn_restart;
  logic        result_valid;
  logic [3:0]  result_class;
  logic        result_err;
  logic [15:0] frames_done;

  int errors = 0;
  int checks = 0;

  fnn_input_feeder dut (
    .clk(clk), .restart(restart),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .fnn_ready(fnn_ready), .fnn_accept(fnn_accept),
    .start_fnn(start_fnn), .ready_in(ready_in), .input_image(input_image),
    .finish_fnn(finish_fnn), .max_in(max_in), .fnn_restart(fnn_restart),
    .result_valid(result_valid), .result_class(result_class),
    .result_err(result_err), .frames_done(frames_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_img(int idx, int off);
    int v;
    v = (idx + off) % 256;
    return 16'(v * 128);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_frame(int cnt, int off);
    int guard;
    for (int i = 0; i < cnt; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'((i + off) % 256);
      guard = 0;
      while (!pix_ready && guard < 100) begin
        tick();
        guard++;
      end
      if (!pix_ready) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout pixel=%0d pix_ready=%0b required 1", i, pix_ready);
        break;
      end
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_start();
    int guard;
    guard = 0;
    while (!start_fnn && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (start_fnn !== 1'b1) begin
      errors++;
      $display("FAIL start_timeout start_fnn=%0b required 1", start_fnn);
    end
  endtask

  task automatic test_reset();
    restart = 1'b1;
    repeat (2) tick();
    checks++;
    if ({pix_ready, start_fnn, ready_in, input_image, fnn_restart, result_valid,
         result_class, result_err, frames_done} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs pix_ready=%0b start=%0b img=%h fd=%0d required all 0",
               pix_ready, start_fnn, input_image, frames_done);
    end
    restart = 1'b0;
    tick();
    checks++;
    if (pix_ready !== 1'b1 || start_fnn !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill pix_ready=%0b start=%0b required 1/0", pix_ready, start_fnn);
    end
  endtask

  task automatic test_fill_stream();
    fnn_ready  = 1'b1;
    fnn_accept = 1'b1;
    feed_frame(N, 0);
    checks++;
    if (start_fnn !== 1'b0) begin
      errors++;
      $display("FAIL arm_start start_fnn=%0b required 0", start_fnn);
    end
`ifndef FNN_FEEDER_DOUBLE_BUFFER_EN
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL arm_pix_ready pix_ready=%0b required 0", pix_ready);
    end
`endif
    tick();
    checks++;
    if (start_fnn !== 1'b1 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL stream_start start=%0b ready_in=%0b required 1/1", start_fnn, ready_in);
    end
    for (int k = 0; k < N; k++) begin
      tick();
      checks++;
      if (input_image !== exp_img(k, 0)) begin
        errors++;
        $display("FAIL stream_seq k=%0d img=%h required %h", k, input_image, exp_img(k, 0));
      end
      if (k == 255) begin
        checks++;
        if (input_image !== 16'h7F80) begin
          errors++;
          $display("FAIL pixel255 img=%h required 7f80", input_image);
        end
      end
    end
    repeat (4) tick();
    checks++;
    if (input_image !== exp_img(N - 1, 0)) begin
      errors++;
      $display("FAIL stream_extra img=%h required %h", input_image, exp_img(N - 1, 0));
    end
    fnn_accept = 1'b0;
  endtask

  task automatic test_result();
    max_in     = 4'd2;
    finish_fnn = 1'b1;
    tick();
    finish_fnn = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result_class !== 4'd2 || result_err !== 1'b0 ||
        frames_done !== 16'd1 || fnn_restart !== 1'b0) begin
      errors++;
      $display("FAIL result_capture v=%0b c=%0d e=%0b fd=%0d rs=%0b required 1/2/0/1/0",
               result_valid, result_class, result_err, frames_done, fnn_restart);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || fnn_restart !== 1'b1 || start_fnn !== 1'b0 ||
        ready_in !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL rearm v=%0b rs=%0b st=%0b ri=%0b pr=%0b required 0/1/0/0/1",
               result_valid, fnn_restart, start_fnn, ready_in, pix_ready);
    end
    max_in     = 4'd7;
    finish_fnn = 1'b1;
    tick();
    finish_fnn = 1'b0;
    checks++;
    if (fnn_restart !== 1'b0 || result_valid !== 1'b0 || result_class !== 4'd2 ||
        pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL finish_ignored rs=%0b v=%0b c=%0d pr=%0b required 0/0/2/1",
               fnn_restart, result_valid, result_class, pix_ready);
    end
  endtask

  task automatic test_accept_toggle();
    int k;
    int cyc;
    logic acc;
    logic [15:0] prev;
    logic [15:0] want;
    fnn_accept = 1'b0;
    feed_frame(N, 100);
    wait_start();
    prev = input_image;
    k = 0;
    cyc = 0;
    while (k < N && cyc < 4000) begin
      acc = (cyc % 2 == 0);
      fnn_accept = acc;
      tick();
      if (acc) k++;
      want = (k == 0) ? prev : exp_img(k - 1, 100);
      checks++;
      if (input_image !== want) begin
        errors++;
        $display("FAIL toggle_seq cyc=%0d img=%h required %h", cyc, input_image, want);
      end
      cyc++;
    end
    checks++;
    if (k != N) begin
      errors++;
      $display("FAIL toggle_count updates=%0d required %0d", k, N);
    end
    for (int j = 0; j < 4; j++) begin
      fnn_accept = (j % 2 == 0);
      tick();
    end
    fnn_accept = 1'b0;
    checks++;
    if (input_image !== exp_img(N - 1, 100)) begin
      errors++;
      $display("FAIL toggle_hold img=%h required %h", input_image, exp_img(N - 1, 100));
    end
  endtask

  task automatic test_result_err();
    max_in     = 4'd12;
    finish_fnn = 1'b1;
    tick();
    finish_fnn = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result_class !== 4'd12 || result_err !== 1'b1 ||
        frames_done !== 16'd2) begin
      errors++;
      $display("FAIL result_err v=%0b c=%0d e=%0b fd=%0d required 1/12/1/2",
               result_valid, result_class, result_err, frames_done);
    end
    tick();
    checks++;
    if (fnn_restart !== 1'b1 || result_err !== 1'b1) begin
      errors++;
      $display("FAIL err_hold rs=%0b e=%0b required 1/1", fnn_restart, result_err);
    end
    tick();
  endtask

  task automatic test_restart_mid();
    feed_frame(N, 0);
    wait_start();
    fnn_accept = 1'b1;
    repeat (400) tick();
    checks++;
    if (input_image !== exp_img(399, 0)) begin
      errors++;
      $display("FAIL mid_stream img=%h required %h", input_image, exp_img(399, 0));
    end
    restart = 1'b1;
    tick();
    checks++;
    if ({pix_ready, start_fnn, ready_in, input_image, fnn_restart, result_valid,
         result_class, result_err, frames_done} !== 42'd0) begin
      errors++;
      $display("FAIL restart_outputs pr=%0b st=%0b img=%h rs=%0b c=%0d fd=%0d required all 0",
               pix_ready, start_fnn, input_image, fnn_restart, result_class, frames_done);
    end
    restart    = 1'b0;
    fnn_accept = 1'b0;
    tick();
    checks++;
    if (pix_ready !== 1'b1 || start_fnn !== 1'b0 || fnn_restart !== 1'b0) begin
      errors++;
      $display("FAIL restart_fill pr=%0b st=%0b rs=%0b required 1/0/0",
               pix_ready, start_fnn, fnn_restart);
    end
    feed_frame(N - 1, 50);
    repeat (3) tick();
    checks++;
    if (start_fnn !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL partial_frame st=%0b pr=%0b required 0/1", start_fnn, pix_ready);
    end
    fnn_ready = 1'b0;
    feed_frame(1, 50 + N - 1);
    repeat (3) tick();
    checks++;
    if (start_fnn !== 1'b0) begin
      errors++;
      $display("FAIL arm_wait start_fnn=%0b required 0", start_fnn);
    end
    fnn_ready = 1'b1;
    tick();
    checks++;
    if (start_fnn !== 1'b1) begin
      errors++;
      $display("FAIL arm_release start_fnn=%0b required 1", start_fnn);
    end
    fnn_accept = 1'b1;
    tick();
    checks++;
    if (input_image !== 16'h1900) begin
      errors++;
      $display("FAIL fresh_first img=%h required 1900", input_image);
    end
    repeat (N - 1) tick();
    fnn_accept = 1'b0;
    checks++;
    if (input_image !== exp_img(N - 1, 50)) begin
      errors++;
      $display("FAIL fresh_last img=%h required %h", input_image, exp_img(N - 1, 50));
    end
    max_in     = 4'd9;
    finish_fnn = 1'b1;
    tick();
    finish_fnn = 1'b0;
    checks++;
    if (result_class !== 4'd9 || result_err !== 1'b0 || frames_done !== 16'd1) begin
      errors++;
      $display("FAIL post_restart_result c=%0d e=%0b fd=%0d required 9/0/1",
               result_class, result_err, frames_done);
    end
    tick();
  endtask

`ifdef FNN_FEEDER_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    fnn_accept = 1'b0;
    feed_frame(N, 10);
    wait_start();
    fork
      feed_frame(N, 20);
      begin
        fnn_accept = 1'b1;
        for (int k = 0; k < N; k++) begin
          tick();
          checks++;
          if (input_image !== exp_img(k, 10) || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL db_stream k=%0d img=%h pr=%0b required %h/1",
                     k, input_image, pix_ready, exp_img(k, 10));
          end
          if (k == N - 2) break;
        end
        tick();
        fnn_accept = 1'b0;
      end
    join
    fnn_accept = 1'b0;
    tick();
    max_in     = 4'd3;
    finish_fnn = 1'b1;
    tick();
    finish_fnn = 1'b0;
    tick();
    checks++;
    if (fnn_restart !== 1'b1) begin
      errors++;
      $display("FAIL db_rearm fnn_restart=%0b required 1", fnn_restart);
    end
    tick();
    checks++;
    if (start_fnn !== 1'b1) begin
      errors++;
      $display("FAIL db_no_fill start_fnn=%0b required 1", start_fnn);
    end
    fnn_accept = 1'b1;
    tick();
    fnn_accept = 1'b0;
    checks++;
    if (input_image !== exp_img(0, 20)) begin
      errors++;
      $display("FAIL db_second img=%h required %h", input_image, exp_img(0, 20));
    end
  endtask
`endif

  initial begin
    restart    = 1'b1;
    pix_valid  = 1'b0;
    pix_data   = 8'd0;
    fnn_ready  = 1'b0;
    fnn_accept = 1'b0;
    finish_fnn = 1'b0;
    max_in     = 4'd0;
    test_reset();
    test_fill_stream();
    test_result();
    test_accept_toggle();
    test_result_err();
    test_restart_mid();
`ifdef FNN_FEEDER_DOUBLE_BUFFER_EN
    test_double_buffer();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
